cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 70 +++++++
 tb/tb_cache_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter that shares one fixed-latency cache port between two requesters.
// Each access drives the cache inputs for LATENCY cycles, then acks the owner for one cycle.
module cache_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        mode0,
  input  logic        mode1,
  input  logic [31:0] address0,
  input  logic [31:0] address1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic        busy,
  output logic [31:0] cache_address,
  output logic [31:0] cache_data,
  output logic        cache_mode,
  input  logic [31:0] cache_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  localparam logic [3:0] LAT = 4'(LATENCY);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic last, gnt, pick, any, fin;
  assign any = req0 | req1;
  // last holds the previous winner, so a tie goes to the other requester
  assign pick = (req0 & req1) ? ~last : req1;
  assign fin = (state == ISSUE) && (cnt == LAT);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE) ? (any ? ISSUE : IDLE) : (state == ISSUE) ? (fin ? DONE : ISSUE) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      last <= 1'b1;
      gnt <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      out0 <= '0;
      out1 <= '0;
      cache_address <= '0;
      cache_data <= '0;
      cache_mode <= 1'b0;
    end else begin
      ack0 <= fin & ~gnt;
      ack1 <= fin & gnt;
      if (state == IDLE && any) begin
        gnt <= pick;
        last <= pick;
        cache_address <= pick ? address1 : address0;
        cache_data <= pick ? data1 : data0;
        cache_mode <= pick ? mode1 : mode0;
        cnt <= 4'd1;
      end else if (state == ISSUE && cnt < LAT) cnt <= cnt + 4'd1;
      else if (fin) cache_mode <= 1'b0;
      if (fin && !cache_mode && !gnt) out0 <= cache_out;
      if (fin && !cache_mode && gnt) out1 <= cache_out;
    end
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed and random checks of cache_arbiter against a transaction-level model.
module tb_cache_arbiter;
  localparam int L = 4;
  localparam logic [31:0] K1 = 32'h5a5a_0000;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic req0 = 0, req1 = 0, mode0 = 0, mode1 = 0;
  logic [31:0] address0 = 0, address1 = 0, data0 = 0, data1 = 0, cache_out = 0;
  logic ack0, ack1, busy, cache_mode;
  logic [31:0] out0, out1, cache_address, cache_data;
  cache_arbiter #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .address0(address0), .address1(address1), .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .out0(out0), .out1(out1), .busy(busy),
    .cache_address(cache_address), .cache_data(cache_data), .cache_mode(cache_mode),
    .cache_out(cache_out)
  );
  logic l1_req0 = 0, l1_req1 = 0, l1_mode0 = 0, l1_mode1 = 0;
  logic [31:0] l1_address0 = 0, l1_address1 = 0, l1_data0 = 0, l1_data1 = 0, l1_cache_out;
  logic l1_ack0, l1_ack1, l1_busy, l1_cache_mode;
  logic [31:0] l1_out0, l1_out1, l1_cache_address, l1_cache_data;
  assign l1_cache_out = l1_cache_address ^ K1;
  cache_arbiter #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req0(l1_req0), .req1(l1_req1), .mode0(l1_mode0), .mode1(l1_mode1),
    .address0(l1_address0), .address1(l1_address1), .data0(l1_data0), .data1(l1_data1),
    .ack0(l1_ack0), .ack1(l1_ack1), .out0(l1_out0), .out1(l1_out1), .busy(l1_busy),
    .cache_address(l1_cache_address), .cache_data(l1_cache_data), .cache_mode(l1_cache_mode),
    .cache_out(l1_cache_out)
  );
  // ideal cache_and_ram environment: full memory, unwritten words read as zero
  logic [31:0] env_mem [logic [31:0]];
  always @(posedge clk) if (cache_mode) env_mem[cache_address] = cache_data;
  always @(negedge clk) cache_out = env_mem.exists(cache_address) ? env_mem[cache_address] : 32'd0;
  int checks = 0, errors = 0;
  int n = 0, g_edge = -100, ack_edge = -100, free_at = 0, cur_g = 0, last_g = 1;
  logic cur_w = 0;
  logic [31:0] cur_a = 0, cur_d = 0;
  logic [31:0] e_out [2];
  logic [31:0] model_mem [logic [31:0]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    g_edge = -100; ack_edge = -100; free_at = 0; cur_g = 0; last_g = 1;
    cur_w = 0; cur_a = 0; cur_d = 0; e_out[0] = 0; e_out[1] = 0;
  endtask
  // transaction view: grant at edge E, ack after E+L, next grant no earlier than E+L+2
  task automatic model();
    n++;
    if (rst) return;
    if (n == ack_edge && !cur_w) e_out[cur_g] = model_mem.exists(cur_a) ? model_mem[cur_a] : 32'd0;
    if (n >= free_at && (req0 || req1)) begin
      cur_g = (req0 && req1) ? 1 - last_g : (req1 ? 1 : 0);
      last_g = cur_g;
      cur_w = cur_g ? mode1 : mode0;
      cur_a = cur_g ? address1 : address0;
      cur_d = cur_g ? data1 : data0;
      if (cur_w) model_mem[cur_a] = cur_d;
      g_edge = n; ack_edge = n + L; free_at = n + L + 2;
    end
  endtask
  task automatic check_cycle();
    chk("ack0", ack0, n == ack_edge && cur_g == 0);
    chk("ack1", ack1, n == ack_edge && cur_g == 1);
    chk("busy", busy, n >= g_edge && n < free_at - 1);
    chk("cache_mode", cache_mode, cur_w && n >= g_edge && n < ack_edge);
    chk("out0", out0, e_out[0]);
    chk("out1", out1, e_out[1]);
    chk("cache_address", cache_address, cur_a);
    chk("cache_data", cache_data, cur_d);
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    #1;
    check_cycle();
    @(negedge clk);
  endtask
  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1001425;
      2: return 32'd2816867292;
      3: return 32'd3036;
      default: return 32'($urandom_range(0, 15));
    endcase
  endfunction
  task automatic agents(input int p_hold, input bit raise);
    if (ack0) begin
      req0 = $urandom_range(0, 99) < p_hold;
      mode0 = 1'($urandom_range(0, 1)); address0 = pick_addr(); data0 = $urandom;
    end else if (raise && !req0 && $urandom_range(0, 2) == 0) begin
      req0 = 1; mode0 = 1'($urandom_range(0, 1)); address0 = pick_addr(); data0 = $urandom;
    end
    if (ack1) begin
      req1 = $urandom_range(0, 99) < p_hold;
      mode1 = 1'($urandom_range(0, 1)); address1 = pick_addr(); data1 = $urandom;
    end else if (raise && !req1 && $urandom_range(0, 2) == 0) begin
      req1 = 1; mode1 = 1'($urandom_range(0, 1)); address1 = pick_addr(); data1 = $urandom;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 30 && (req0 || req1 || busy); i++) begin
      tick();
      agents(0, 0);
    end
    chk("drain", {req0, req1, busy}, 0);
  endtask
  task automatic access(input bit r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int mcyc, output int acks);
    mcyc = 0; acks = 0;
    if (r) begin req1 = 1; mode1 = w; address1 = a; data1 = d; end
    else begin req0 = 1; mode0 = w; address0 = a; data0 = d; end
    for (int i = 0; i < L + 6; i++) begin
      tick();
      mcyc += cache_mode ? 1 : 0;
      if (r ? ack1 : ack0) begin
        acks++;
        if (r) req1 = 0; else req0 = 0;
      end
    end
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    check_cycle();
    @(negedge clk);
    tick();
    rst = 0;
  endtask
  initial begin
    int m, a;
    int order [$];
    #2;
    do_reset();
    access(0, 1, 32'd0, 32'd14528, m, a);
    chk("w_mode_cycles", m, L);
    chk("w_ack_count", a, 1);
    chk("w_out0", out0, 0);
    access(1, 1, 32'd1001425, 32'd25369366, m, a);
    chk("w1_ack_count", a, 1);
    access(1, 0, 32'd1001425, 32'd0, m, a);
    chk("rd_out1", out1, 32'd25369366);
    chk("rd_out0", out0, 0);
    chk("rd_mode_cycles", m, 0);
    access(0, 1, 32'd2816867292, 32'd526421, m, a);
    access(0, 1, 32'd3036, 32'd14528, m, a);
    access(0, 0, 32'd2816867292, 32'd0, m, a);
    chk("alias_out0", out0, 32'd526421);
    @(negedge clk);
    do_reset();
    req0 = 1; mode0 = 0; address0 = 32'd3036; data0 = 0;
    req1 = 1; mode1 = 0; address1 = 32'd1001425; data1 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("ack_overlap", ack0 & ack1, 0);
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
      agents(100, 0);
    end
    for (int i = 0; i < 4; i++) chk("rr_order", order.size() > i ? order[i] : -1, i % 2);
    drain();
    req0 = 1; mode0 = 1; address0 = 32'd77; data0 = 32'hdead_beef;
    tick();
    tick();
    rst = 1;
    #1;
    chk("rst_mode", cache_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    model_reset();
    req0 = 0;
    @(negedge clk);
    tick();
    rst = 0;
    access(0, 0, 32'd5, 32'd0, m, a);
    chk("post_rst_acks", a, 1);
    for (int i = 0; i < 300; i++) begin
      tick();
      chk("ack_overlap", ack0 & ack1, 0);
      agents(50, 1);
    end
    drain();
    l1_req0 = 1; l1_address0 = 32'd123;
    tick();
    chk("l1_ack_e0", l1_ack0, 0);
    tick();
    chk("l1_ack_e1", l1_ack0, 1);
    chk("l1_out0", l1_out0, 32'd123 ^ K1);
    l1_req0 = 0;
    tick();
    chk("l1_ack_e2", l1_ack0, 0);
    chk("l1_busy_e2", l1_busy, 0);
    l1_req0 = 1; l1_address0 = 32'd9;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("l1_b2b_ack", l1_ack0, k % 3 == 1);
      chk("l1_b2b_busy", l1_busy, k % 3 != 2);
      chk("l1_no_ack1", l1_ack1, 0);
    end
    l1_req0 = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
